// File: rtl/rx_message_assembler.sv
// Packs received UART bytes into a 64-bit message closed by fill, terminator or idle timeout.
// Optional feature macro: RX_MSG_TIMEOUT_EN enables the inter-byte idle timeout.
module rx_message_assembler #(
    parameter int         MSG_BYTES      = 8,
    parameter logic [7:0] TERM_BYTE      = 8'h0D,
    parameter int         TIMEOUT_CYCLES = 10416
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  Byte_In,
    input  logic        byte_has_been_received,
    input  logic        message_ack,
    output logic [63:0] Message_Out,
    output logic        message_valid,
    output logic [3:0]  byte_count,
    output logic        overflow
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;
    localparam logic [3:0] FULL_COUNT = 4'(MSG_BYTES);

    if (MSG_BYTES < 1 || MSG_BYTES > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("rx_message_assembler: unsupported parameter set");
    end

    function automatic logic [63:0] insert_byte(input logic [63:0] msg,
                                                input logic [3:0]  idx,
                                                input logic [7:0]  data);
        logic [63:0] res;
        res = msg;
        for (int i = 0; i < 8; i++) begin
            if (idx == 4'(i)) begin
                res[63-8*i -: 8] = data;
            end
        end
        return res;
    endfunction

    logic [1:0]  state_r;
    logic [1:0]  state_nxt_s;
    logic [63:0] msg_nxt_s;
    logic [3:0]  count_nxt_s;
    logic        valid_nxt_s;
    logic        overflow_nxt_s;
    logic        is_term_s;
    logic        timeout_hit_s;

    assign is_term_s = (Byte_In == TERM_BYTE);

`ifdef RX_MSG_TIMEOUT_EN
    localparam int                TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt_r;

    // A byte arriving in the expiry cycle takes priority over the timeout.
    assign timeout_hit_s = (state_r == ST_COLLECT) && (to_cnt_r == TO_LAST) && !byte_has_been_received;

    // Idle counter: clears on bytes and outside COLLECT, saturates at the expiry value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt_r <= '0;
        end else if (byte_has_been_received || (state_r != ST_COLLECT)) begin
            to_cnt_r <= '0;
        end else if (to_cnt_r != TO_LAST) begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
        end else begin
            to_cnt_r <= to_cnt_r;
        end
    end
`else
    assign timeout_hit_s = 1'b0;
`endif

    // Next-state and next-output computation for the assembler FSM.
    always_comb begin
        state_nxt_s    = state_r;
        msg_nxt_s      = Message_Out;
        count_nxt_s    = byte_count;
        valid_nxt_s    = message_valid;
        overflow_nxt_s = overflow;
        case (state_r)
            ST_IDLE: begin
                if (byte_has_been_received && !is_term_s) begin
                    msg_nxt_s   = insert_byte(Message_Out, 4'd0, Byte_In);
                    count_nxt_s = 4'd1;
                    if (FULL_COUNT == 4'd1) begin
                        state_nxt_s = ST_DONE;
                        valid_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_COLLECT;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (byte_has_been_received) begin
                    if (is_term_s) begin
                        state_nxt_s = ST_DONE;
                        valid_nxt_s = 1'b1;
                    end else begin
                        msg_nxt_s   = insert_byte(Message_Out, byte_count, Byte_In);
                        count_nxt_s = byte_count + 4'd1;
                        if ((byte_count + 4'd1) == FULL_COUNT) begin
                            state_nxt_s = ST_DONE;
                            valid_nxt_s = 1'b1;
                        end else begin
                            state_nxt_s = ST_COLLECT;
                        end
                    end
                end else if (timeout_hit_s) begin
                    state_nxt_s = ST_DONE;
                    valid_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = ST_COLLECT;
                end
            end
            ST_DONE: begin
                // Ack wins over a same-cycle byte, which is dropped without flagging overflow.
                if (message_ack) begin
                    state_nxt_s    = ST_IDLE;
                    msg_nxt_s      = 64'h0;
                    count_nxt_s    = 4'd0;
                    valid_nxt_s    = 1'b0;
                    overflow_nxt_s = 1'b0;
                end else if (byte_has_been_received) begin
                    overflow_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s    = ST_IDLE;
                msg_nxt_s      = 64'h0;
                count_nxt_s    = 4'd0;
                valid_nxt_s    = 1'b0;
                overflow_nxt_s = 1'b0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            Message_Out   <= 64'h0;
            byte_count    <= 4'd0;
            message_valid <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            Message_Out   <= msg_nxt_s;
            byte_count    <= count_nxt_s;
            message_valid <= valid_nxt_s;
            overflow      <= overflow_nxt_s;
        end
    end

endmodule
